// File: rtl/qdec_bin_arbiter_pkg.sv
// Shared types and helpers for the CABAC bin arbiter: FSM states, requester ids,
// and the modular index wrap used by the round-robin logic.
package qdec_bin_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_HOLD  = 2'd3
    } t_state_arb;

    typedef enum logic [2:0] {
        REQ_CU       = 3'd0,
        REQ_TRAFO    = 3'd1,
        REQ_TU       = 3'd2,
        REQ_RESIDUAL = 3'd3
    } t_req_id;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // sum is at most 2*(n-1), so a single conditional subtract is enough
    function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W:0] sum, input int n);
        logic [IDX_W:0] s;
        s = sum;
        if (s >= (IDX_W+1)'(n)) begin
            s = s - (IDX_W+1)'(n);
        end
        return s[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/qdec_bin_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr wins.
// The pointer register is owned by the parent.
module qdec_rr_arbiter
    import qdec_bin_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] gnt_pad;
    logic [IDX_W-1:0]   idx;

    // scan from the farthest candidate back to ptr so the nearest one overwrites
    always_comb begin
        req_pad = MAX_REQ'(req);
        gnt_pad = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = rr_wrap({1'b0, ptr} + (IDX_W+1)'(i), NUM_REQ);
            if (req_pad[idx]) begin
                gnt_pad      = '0;
                gnt_pad[idx] = 1'b1;
                gnt_idx      = idx;
                gnt_vld      = 1'b1;
            end
        end
        gnt = gnt_pad[NUM_REQ-1:0];
    end

endmodule

// File: rtl/qdec_bin_arbiter.sv
// Shares one CABAC decoding engine between the syntax sub-FSMs, one bin in flight,
// round-robin between requesters with an optional lock for multi-bin elements.
module qdec_bin_arbiter
    import qdec_bin_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CTX_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_vld,
    input  logic [NUM_REQ*CTX_W-1:0] req_ctx_addr,
    input  logic [NUM_REQ-1:0]       req_ep_mode,
    input  logic [NUM_REQ-1:0]       req_lock,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic                     bin_out,
    output logic [NUM_REQ-1:0]       bin_out_vld,
    output logic [CTX_W-1:0]         eng_ctx_addr,
    output logic                     eng_ep_mode,
    output logic                     eng_run,
    input  logic                     eng_rdy,
    input  logic                     eng_bin,
    input  logic                     eng_bin_vld,
    output logic [IDX_W-1:0]         owner,
    output logic                     busy,
    output logic                     err_timeout,
    output logic                     err_stray,
    output logic [15:0]              bin_count
);

    logic [MAX_REQ-1:0] vld_pad;
    logic [MAX_REQ-1:0] ep_pad;
    logic [MAX_REQ-1:0] lock_pad;
    logic [CTX_W-1:0]   ctx_arr [MAX_REQ];

    t_state_arb         state;
    t_state_arb         state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] owner_oh;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic               lock_q;
    logic [7:0]         timer;

    logic               do_grant;
    logic               do_issue;
    logic               do_route;
    logic               do_timeout;
    logic               do_reload;
    logic               ptr_adv;
    logic               stray;

    assign vld_pad  = MAX_REQ'(req_vld);
    assign ep_pad   = MAX_REQ'(req_ep_mode);
    assign lock_pad = MAX_REQ'(req_lock);

    for (genvar g = 0; g < MAX_REQ; g++) begin : g_ctx
        if (g < NUM_REQ) begin : g_used
            assign ctx_arr[g] = req_ctx_addr[g*CTX_W +: CTX_W];
        end else begin : g_pad
            assign ctx_arr[g] = '0;
        end
    end

    qdec_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_vld),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign busy = (state != ARB_IDLE);

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_issue   = 1'b0;
        do_route   = 1'b0;
        do_timeout = 1'b0;
        do_reload  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (gnt_vld) begin
                    do_grant  = 1'b1;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                do_reload = 1'b1;
                if (eng_rdy) begin
                    do_issue  = 1'b1;
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // a bin arriving on the timeout cycle still counts as a good bin
                if (eng_bin_vld) begin
                    do_route  = 1'b1;
                    state_nxt = lock_q ? ARB_HOLD : ARB_IDLE;
                end else if (timer == 8'(TIMEOUT)) begin
                    do_timeout = 1'b1;
                    state_nxt  = ARB_IDLE;
                end
            end
            ARB_HOLD: begin
                if (vld_pad[owner]) begin
                    do_reload = 1'b1;
                    state_nxt = ARB_ISSUE;
                end else if (!lock_pad[owner]) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        ptr_adv = (state != ARB_IDLE) && (state_nxt == ARB_IDLE);
        stray   = eng_bin_vld && (state != ARB_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            owner_oh     <= '0;
            lock_q       <= 1'b0;
            timer        <= '0;
            eng_ctx_addr <= '0;
            eng_ep_mode  <= 1'b0;
            eng_run      <= 1'b0;
            req_ack      <= '0;
            bin_out      <= 1'b0;
            bin_out_vld  <= '0;
            bin_count    <= '0;
            err_timeout  <= 1'b0;
            err_stray    <= 1'b0;
        end else begin
            state       <= state_nxt;
            eng_run     <= do_issue;
            req_ack     <= do_issue ? owner_oh : '0;
            bin_out_vld <= do_route ? owner_oh : '0;
            if (do_grant) begin
                owner        <= gnt_idx;
                owner_oh     <= gnt;
                eng_ctx_addr <= ctx_arr[gnt_idx];
                eng_ep_mode  <= ep_pad[gnt_idx];
            end else if (do_reload) begin
                eng_ctx_addr <= ctx_arr[owner];
                eng_ep_mode  <= ep_pad[owner];
            end
            if (do_issue) begin
                timer  <= '0;
                lock_q <= lock_pad[owner];
            end else if (state == ARB_WAIT) begin
                timer <= timer + 8'd1;
            end
            if (do_route) begin
                bin_out   <= eng_bin;
                bin_count <= bin_count + 16'd1;
            end
            if (do_timeout) begin
                err_timeout <= 1'b1;
            end
            if (stray) begin
                err_stray <= 1'b1;
            end
            if (ptr_adv) begin
                rr_ptr <= rr_wrap({1'b0, owner} + (IDX_W+1)'(1), NUM_REQ);
            end
        end
    end

endmodule
